// File: rtl/cnn_pkg.sv
// Shared types and helpers for the 3x3 window generator and its bank mux.
package cnn_pkg;

    // Window generator sequencing states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        REL   = 3'd4
    } state_t;

    // Bank holding row k of the current window, counted from the oldest row.
    function automatic logic [1:0] bank_sel(input logic [1:0] base, input logic [1:0] k);
        return base + k;
    endfunction

    // LSB position of pixel (r,c) inside the flattened window vector.
    function automatic int win_idx(input int bd, input int r, input int c);
        return bd * (3 * r + c);
    endfunction

endpackage

// File: rtl/win_bank_mux.sv
// Maps the four bank read ports onto the top/mid/bottom window rows and
// decodes which three banks are read while a row pass is in progress.
module win_bank_mux
    import cnn_pkg::*;
#(
    parameter int bit_depth = 8
) (
    input  logic [1:0]           base_bank,
    input  logic                 read_active,
    input  logic [bit_depth-1:0] in0_q,
    input  logic [bit_depth-1:0] in1_q,
    input  logic [bit_depth-1:0] in2_q,
    input  logic [bit_depth-1:0] in3_q,
    output logic [bit_depth-1:0] top_q,
    output logic [bit_depth-1:0] mid_q,
    output logic [bit_depth-1:0] bot_q,
    output logic [3:0]           rden
);

    logic [bit_depth-1:0] q_arr [4];

    assign q_arr[0] = in0_q;
    assign q_arr[1] = in1_q;
    assign q_arr[2] = in2_q;
    assign q_arr[3] = in3_q;

    // Reorder bank data so row 0 is always the oldest stored row.
    always_comb begin
        top_q = q_arr[bank_sel(base_bank, 2'd0)];
        mid_q = q_arr[bank_sel(base_bank, 2'd1)];
        bot_q = q_arr[bank_sel(base_bank, 2'd2)];
    end

    // Enable the three window banks only; the fourth may be under upstream write.
    always_comb begin
        rden = 4'b0000;
        if (read_active) begin
            rden[bank_sel(base_bank, 2'd0)] = 1'b1;
            rden[bank_sel(base_bank, 2'd1)] = 1'b1;
            rden[bank_sel(base_bank, 2'd2)] = 1'b1;
        end
    end

endmodule

// File: rtl/win3x3_gen.sv
// Sliding 3x3 window generator fed by a 4-bank round-robin row buffer.
// Tracks stored rows, reads the three oldest column by column and emits one
// window per cycle. de_out is a valid-only strobe: there is no ready, the
// consumer must take win_out/out_col/out_row in every cycle de_out is high.
module win3x3_gen
    import cnn_pkg::*;
#(
    parameter int bit_depth    = 8,
    parameter int image_width  = 28,
    parameter int image_height = 28,
    parameter int ADDR_W       = 5,
    parameter int RD_LAT       = 2
) (
    input  logic                   clk,
    input  logic                   RESET,
    input  logic                   start,
    input  logic                   row_done,
    input  logic [bit_depth-1:0]   in0_q,
    input  logic [bit_depth-1:0]   in1_q,
    input  logic [bit_depth-1:0]   in2_q,
    input  logic [bit_depth-1:0]   in3_q,
    output logic                   in0_rden,
    output logic                   in1_rden,
    output logic                   in2_rden,
    output logic                   in3_rden,
    output logic [ADDR_W-1:0]      rd_addr,
    output logic [9*bit_depth-1:0] win_out,
    output logic                   de_out,
    output logic [ADDR_W-1:0]      out_col,
    output logic [11:0]            out_row,
    output logic                   frame_done,
    output logic                   overflow
);

    localparam int DW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    state_t               state_q, state_d;
    logic [2:0]           rows_avail;
    logic [1:0]           base_bank;
    logic [11:0]          rows_out;
    logic [DW-1:0]        drain_cnt;
    logic                 read_active, rel, drain_last, frame_end, last_col;
    logic [RD_LAT-1:0]    pipe_v;
    logic [ADDR_W-1:0]    pipe_col [RD_LAT];
    logic [bit_depth-1:0] new_col [3];
    logic [3:0]           rden;

    assign last_col   = (rd_addr == ADDR_W'(image_width - 1));
    assign drain_last = (drain_cnt == DW'(RD_LAT - 1));
    assign frame_end  = rel && (rows_out == 12'(image_height - 3));

    win_bank_mux #(.bit_depth(bit_depth)) u_mux (
        .base_bank   (base_bank),
        .read_active (read_active),
        .in0_q       (in0_q),
        .in1_q       (in1_q),
        .in2_q       (in2_q),
        .in3_q       (in3_q),
        .top_q       (new_col[0]),
        .mid_q       (new_col[1]),
        .bot_q       (new_col[2]),
        .rden        (rden)
    );

    assign in0_rden = rden[0];
    assign in1_rden = rden[1];
    assign in2_rden = rden[2];
    assign in3_rden = rden[3];

    // State register.
    always_ff @(posedge clk) begin
        if (!RESET) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; dropping start returns to IDLE from anywhere.
    always_comb begin
        state_d = state_q;
        if (!start) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = WAIT;
                WAIT:    if (rows_avail >= 3'd3) state_d = READ;
                READ:    if (last_col) state_d = DRAIN;
                DRAIN:   if (drain_last) state_d = REL;
                REL:     state_d = WAIT;
                default: state_d = IDLE;
            endcase
        end
    end

    // State-decoded controls.
    always_comb begin
        read_active = 1'b0;
        rel         = 1'b0;
        case (state_q)
            READ:    read_active = 1'b1;
            REL:     rel = 1'b1;
            default: ;
        endcase
    end

    // Column address: restarts on READ entry, holds outside READ.
    always_ff @(posedge clk) begin
        if (!RESET) begin
            rd_addr <= '0;
        end else if (state_q == WAIT && state_d == READ) begin
            rd_addr <= '0;
        end else if (read_active && !last_col) begin
            rd_addr <= rd_addr + ADDR_W'(1);
        end
    end

    // Counts the cycles spent waiting for the last reads to return.
    always_ff @(posedge clk) begin
        if (!RESET || state_q != DRAIN) drain_cnt <= '0;
        else                            drain_cnt <= drain_cnt + DW'(1);
    end

    // Row bookkeeping: stored-row count, oldest bank, rows finished, overflow.
    always_ff @(posedge clk) begin
        if (!RESET || !start) begin
            rows_avail <= '0;
            base_bank  <= '0;
            rows_out   <= '0;
            overflow   <= 1'b0;
        end else if (frame_end) begin
            rows_avail <= '0;
            base_bank  <= '0;
            rows_out   <= '0;
        end else begin
            if (rel) begin
                base_bank <= base_bank + 2'd1;
                rows_out  <= rows_out + 12'd1;
            end
            case ({row_done, rel})
                2'b10: begin
                    if (rows_avail == 3'd4) overflow   <= 1'b1;
                    else                    rows_avail <= rows_avail + 3'd1;
                end
                2'b01:   rows_avail <= rows_avail - 3'd1;
                default: ;
            endcase
        end
    end

    // Read-return pipeline, window shift register and output strobes.
    always_ff @(posedge clk) begin
        if (!RESET) begin
            pipe_v     <= '0;
            for (int i = 0; i < RD_LAT; i++) pipe_col[i] <= '0;
            win_out    <= '0;
            de_out     <= 1'b0;
            out_col    <= '0;
            out_row    <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= start && frame_end;
            if (!start) begin
                pipe_v <= '0;
                de_out <= 1'b0;
            end else begin
                pipe_v[0]   <= read_active;
                pipe_col[0] <= rd_addr;
                for (int i = 1; i < RD_LAT; i++) begin
                    pipe_v[i]   <= pipe_v[i-1];
                    pipe_col[i] <= pipe_col[i-1];
                end
                if (pipe_v[RD_LAT-1]) begin
                    for (int r = 0; r < 3; r++) begin
                        win_out[win_idx(bit_depth, r, 0) +: bit_depth] <= win_out[win_idx(bit_depth, r, 1) +: bit_depth];
                        win_out[win_idx(bit_depth, r, 1) +: bit_depth] <= win_out[win_idx(bit_depth, r, 2) +: bit_depth];
                        win_out[win_idx(bit_depth, r, 2) +: bit_depth] <= new_col[r];
                    end
                    de_out  <= (pipe_col[RD_LAT-1] >= ADDR_W'(2));
                    out_col <= pipe_col[RD_LAT-1] - ADDR_W'(1);
                    out_row <= rows_out + 12'd1;
                end else begin
                    de_out <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_win3x3_gen.sv
// Bench for win3x3_gen: upstream row writer plus 4-bank memory model,
// image-level reference windows queued per row, monitor popping on de_out.
module tb_win3x3_gen;

  localparam int BD = 8;
  localparam int IW = 28;
  localparam int IH = 28;
  localparam int AW = 5;
  localparam int EW = 9 * BD + AW + 12;

  // clock / reset
  logic clk = 1'b0;
  logic RESET;
  always #5 clk = ~clk;

  logic          start, row_done;
  logic [BD-1:0] q [4];
  logic [BD-1:0] s1 [4];
  logic          in0_rden, in1_rden, in2_rden, in3_rden;
  logic [AW-1:0] rd_addr;
  logic [9*BD-1:0] win_out;
  logic          de_out;
  logic [AW-1:0] out_col;
  logic [11:0]   out_row;
  logic          frame_done, overflow;
  logic [3:0]    rden_v;

  assign rden_v = {in3_rden, in2_rden, in1_rden, in0_rden};

  win3x3_gen #(
    .bit_depth(BD), .image_width(IW), .image_height(IH), .ADDR_W(AW), .RD_LAT(2)
  ) dut (
    .clk(clk), .RESET(RESET), .start(start), .row_done(row_done),
    .in0_q(q[0]), .in1_q(q[1]), .in2_q(q[2]), .in3_q(q[3]),
    .in0_rden(in0_rden), .in1_rden(in1_rden), .in2_rden(in2_rden), .in3_rden(in3_rden),
    .rd_addr(rd_addr), .win_out(win_out), .de_out(de_out), .out_col(out_col),
    .out_row(out_row), .frame_done(frame_done), .overflow(overflow)
  );

  // bank memories with two-cycle read latency; idle banks return noise
  logic [BD-1:0] mem [4][32];
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      s1[b] <= rden_v[b] ? mem[b][rd_addr] : BD'($urandom);
      q[b]  <= s1[b];
    end
  end

  // scoreboard state
  logic [EW-1:0] exp_q[$];
  logic [BD-1:0] img [IH][IW];
  int checks = 0;
  int errors = 0;
  int fr = 0;
  int top_row = 0;
  int bursts = 0;
  int fd_cnt = 0;
  int pops = 0;
  int cyc = 0;
  int t_issue0 = 0;
  bit mon_en = 1'b0;
  bit prev_any = 1'b0;
  bit prev_de = 1'b0;
  int prev_col = 0;
  int prev_row = 0;

  function automatic void chk(string name, logic [127:0] got, logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", name, got, exp);
    end
  endfunction

  // reference: all 26 windows centred on image row r_c
  function automatic void push_row(int r_c);
    logic [9*BD-1:0] w;
    for (int cc = 1; cc <= IW - 2; cc++) begin
      w = '0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          w[BD*(3*r+c) +: BD] = img[r_c-1+r][cc-1+c];
      exp_q.push_back({w, AW'(cc), 12'(r_c)});
    end
  endfunction

  // monitor
  always @(negedge clk) begin
    logic [3:0] exp_p;
    logic [EW-1:0] e;
    cyc++;
    if (|rden_v && !prev_any) begin
      exp_p = 4'b1111;
      exp_p[(top_row + 3) % 4] = 1'b0;
      chk("burst_banks_addr", {rden_v, 3'b0, rd_addr}, {exp_p, 8'h00});
      top_row++;
      bursts++;
      t_issue0 = cyc;
    end
    prev_any = |rden_v;
    if (frame_done) fd_cnt++;
    if (mon_en && de_out) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_window", {out_row, 3'b0, out_col}, 20'hFFFFF);
      end else begin
        e = exp_q.pop_front();
        pops++;
        chk("window", {win_out, out_col, out_row}, e);
      end
      if (out_col == 1) chk("first_window_latency", cyc - t_issue0, 5);
      else chk("window_no_gap", {prev_de, 7'(prev_col)}, {1'b1, 7'(out_col - 1)});
    end
    if (mon_en && frame_done)
      chk("frame_done_after_last", {prev_de, 12'(prev_row), 7'(prev_col)}, {1'b1, 12'(IH-2), 7'(IW-2)});
    prev_de = de_out;
    prev_col = out_col;
    prev_row = out_row;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_cycles(int n);
    repeat (n) tick();
  endtask

  task automatic new_frame();
    fr = 0;
    top_row = 0;
  endtask

  task automatic send_row(bit pattern);
    for (int c = 0; c < IW; c++) begin
      img[fr][c] = pattern ? BD'((16 * fr + c) & 255) : BD'($urandom_range(0, 255));
      mem[fr % 4][c] = img[fr][c];
    end
    if (fr >= 2 && fr <= IH - 1) push_row(fr - 1);
    row_done = 1'b1;
    tick();
    row_done = 1'b0;
    fr++;
  endtask

  task automatic wait_rd_col(int col, int budget, string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(|rden_v && rd_addr == AW'(col)) && n < budget);
    chk(name, n < budget, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic wait_drain(int budget, string name);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  task automatic check_zero(string name);
    @(negedge clk);
    chk(name, {rden_v, rd_addr, win_out[71:32]}, '0);
    chk({name, "_b"}, {win_out[31:0], de_out, out_col, out_row, frame_done, overflow}, '0);
    @(posedge clk); #1;
  endtask

  // stimulus
  initial begin
    int n;
    bit bad;
    RESET = 1'b0;
    start = 1'b0;
    row_done = 1'b0;
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 32; a++) mem[b][a] = '0;
    wait_cycles(3);
    check_zero("reset_state");
    RESET = 1'b1;
    start = 1'b1;
    wait_cycles(2);

    // full frame, pattern 16*row+col, rows 40 cycles apart
    new_frame();
    mon_en = 1'b1;
    for (int k = 0; k < IH; k++) begin
      send_row(1'b1);
      wait_cycles(39);
    end
    wait_drain(200, "frame_a_drain");
    wait_cycles(5);
    chk("frame_a_windows", pops, (IH - 2) * (IW - 2));
    chk("frame_a_done_count", fd_cnt, 1);

    // row_done coincident with the release cycle
    new_frame();
    bursts = 0;
    send_row(1'b0); wait_cycles(39);
    send_row(1'b0); wait_cycles(39);
    send_row(1'b0);
    n = 0;
    do begin @(negedge clk); n++; end while (!(|rden_v) && n < 20);
    do begin @(negedge clk); n++; end while ((|rden_v) && n < 60);
    chk("rel_find_read_end", n < 60, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    send_row(1'b0);
    wait_drain(120, "coincident_drain");
    wait_cycles(50);
    chk("coincident_bursts", bursts, 2);
    chk("coincident_no_overflow", overflow, 1'b0);

    // start=0 mid-row, then restart
    send_row(1'b0);
    wait_rd_col(10, 60, "start_low_find_col");
    start = 1'b0;
    tick();
    @(negedge clk);
    chk("start_low_rden", {rden_v, de_out}, 5'b0);
    @(posedge clk); #1;
    exp_q.delete();
    new_frame();
    start = 1'b1;
    bad = 1'b0;
    for (int k = 0; k < 2; k++) begin
      send_row(1'b0);
      repeat (39) begin
        @(negedge clk);
        if (|rden_v || de_out) bad = 1'b1;
        @(posedge clk); #1;
      end
    end
    chk("restart_rden_low_until_3_rows", bad, 1'b0);
    send_row(1'b0);
    wait_cycles(39);

    // reset mid-row, then restart a new frame
    for (int k = 3; k <= 6; k++) begin
      send_row(1'b0);
      if (k < 6) wait_cycles(39);
    end
    wait_rd_col(10, 60, "reset_find_col");
    RESET = 1'b0;
    mon_en = 1'b0;
    tick();
    check_zero("reset_mid_row");
    bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (de_out) bad = 1'b1;
      @(posedge clk); #1;
    end
    chk("no_de_in_reset", bad, 1'b0);
    exp_q.delete();
    RESET = 1'b1;
    new_frame();
    mon_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      send_row(1'b0);
      wait_cycles(39);
    end
    wait_drain(100, "after_reset_drain");

    // overflow: five back-to-back rows without release
    mon_en = 1'b0;
    start = 1'b0;
    tick();
    start = 1'b1;
    new_frame();
    bursts = 0;
    for (int k = 0; k < 5; k++) send_row(1'b0);
    wait_cycles(2);
    chk("overflow_set", overflow, 1'b1);
    wait_cycles(150);
    chk("overflow_sticky", overflow, 1'b1);
    chk("overflow_saturated_bursts", bursts, 2);
    start = 1'b0;
    tick();
    @(negedge clk);
    chk("overflow_clear_start0", overflow, 1'b0);
    @(posedge clk); #1;
    exp_q.delete();
    chk("frame_done_total", fd_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // watchdog
  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
